// File: rtl/pulse_window_counter.sv
// Counts rising edges of a registered pulse flag over programmable windows of
// clock cycles. Each window's saturating count goes out on a valid/ready register.
module pulse_window_counter #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_ovf,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             drop
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q;
  logic               p1_q, p2_q;
  logic [WIN_W-1:0]   len_q, timer_q;
  logic [CNT_W-1:0]   acc_q;
  logic               ovf_acc_q;
  logic [CNT_W-1:0]   cnt_out_q;
  logic               cnt_ovf_q, cnt_valid_q, drop_q;

  logic               pulse_event;
  logic               acc_full;
  logic [CNT_W-1:0]   acc_d;
  logic               ovf_d;
  logic [WIN_W-1:0]   len_d;
  logic               win_end;
  logic               out_free;

  always_comb begin
    pulse_event = p1_q & ~p2_q;
    acc_full    = &acc_q;
    acc_d       = (pulse_event && !acc_full) ? acc_q + 1'b1 : acc_q;
    ovf_d       = ovf_acc_q | (pulse_event & acc_full);
    // A zero window length would never end; treat it as a 1-cycle window.
    len_d       = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
    win_end     = (state_q == RUN) && (timer_q == len_q - 1'b1);
    out_free    = !cnt_valid_q || cnt_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      len_q       <= {{(WIN_W-1){1'b0}}, 1'b1};
      timer_q     <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_out_q   <= '0;
      cnt_ovf_q   <= 1'b0;
      cnt_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      p1_q   <= pulse_in;
      p2_q   <= p1_q;
      drop_q <= 1'b0;
      // NOTE: non-blocking updates make the last assignment win, so a load
      // below overrides this accept-clear on a simultaneous accept and load.
      if (cnt_valid_q && cnt_ready) cnt_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          timer_q   <= '0;
          acc_q     <= '0;
          ovf_acc_q <= 1'b0;
          if (enable) begin
            state_q <= RUN;
            len_q   <= len_d;
          end
        end
        RUN: begin
          if (win_end) begin
            timer_q   <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            if (enable) len_q   <= len_d;
            else        state_q <= IDLE;
            if (out_free) begin
              cnt_out_q   <= acc_d;
              cnt_ovf_q   <= ovf_d;
              cnt_valid_q <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
          end else begin
            timer_q   <= timer_q + 1'b1;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_out   = cnt_out_q;
  assign cnt_ovf   = cnt_ovf_q;
  assign cnt_valid = cnt_valid_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench for pulse_window_counter: a window/event model compared every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_pulse_window_counter;

  localparam int WIN_W   = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pulse_in = 1'b0;
  logic             enable = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_ovf, cnt_valid, drop;
  logic             cnt_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  pulse_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .enable    (enable),
    .win_len   (win_len),
    .cnt_out   (cnt_out),
    .cnt_ovf   (cnt_ovf),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pulse_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Model: an event at edge t is "pulse sampled high at t-1 and low at t-2".
  // A window counts raw events over its L edges; the result is min(raw, max).
  bit          h1 = 0, h2 = 0;
  bit          m_run = 0;
  int          m_left = 0, m_raw = 0;
  bit          m_ev, m_got, m_res_ovf;
  int          m_res_cnt;
  bit          exp_valid = 0, exp_ovf = 0, exp_drop = 0;
  int          exp_out = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 = 0; h2 = 0; m_run = 0; m_left = 0; m_raw = 0;
      exp_valid = 0; exp_ovf = 0; exp_drop = 0; exp_out = 0;
    end else begin
      m_ev  = h1 & ~h2;
      m_got = 0;
      if (!m_run) begin
        if (enable) begin
          m_run  = 1;
          m_left = (win_len == 0) ? 1 : int'(win_len);
          m_raw  = 0;
        end
      end else begin
        m_raw  += int'(m_ev);
        m_left -= 1;
        if (m_left == 0) begin
          m_got     = 1;
          m_res_cnt = (m_raw > CNT_MAX) ? CNT_MAX : m_raw;
          m_res_ovf = (m_raw > CNT_MAX);
          if (enable) begin
            m_left = (win_len == 0) ? 1 : int'(win_len);
            m_raw  = 0;
          end else begin
            m_run = 0;
          end
        end
      end
      exp_drop = 0;
      if (m_got) begin
        if (!exp_valid || cnt_ready) begin
          exp_valid = 1; exp_out = m_res_cnt; exp_ovf = m_res_ovf;
        end else begin
          exp_drop = 1;
        end
      end else if (exp_valid && cnt_ready) begin
        exp_valid = 0;
      end
      h2 = h1;
      h1 = pulse_in;
    end
  end

  always @(negedge clk) begin
    check("cmp_valid", int'(cnt_valid), int'(exp_valid));
    check("cmp_drop", int'(drop), int'(exp_drop));
    if (exp_valid) begin
      check("cmp_out", int'(cnt_out), exp_out);
      check("cmp_ovf", int'(cnt_ovf), int'(exp_ovf));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with pulse toggling, then idle with enable low.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_in = ~pulse_in;
      tick();
    end
    check("rst_valid", int'(cnt_valid), 0);
    check("rst_out", int'(cnt_out), 0);
    check("rst_ovf", int'(cnt_ovf), 0);
    check("rst_drop", int'(drop), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_in = ~pulse_in;
      tick();
    end
    check("idle_no_valid", int'(cnt_valid), 0);
    idle(2);

    // Basic count: three isolated pulses in a 10-cycle window; enable drops
    // right after entry, so this window completes and the block returns to IDLE.
    win_len = 10; cnt_ready = 1'b1; enable = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      pulse_in = (i == 1 || i == 3 || i == 5);
      if (i == 1) enable = 1'b0;
      tick();
      if (i == 9) check("basic_not_yet", int'(cnt_valid), 0);
    end
    check("basic_valid", int'(cnt_valid), 1);
    check("basic_out", int'(cnt_out), 3);
    check("basic_ovf", int'(cnt_ovf), 0);
    idle(15);
    check("basic_then_idle", int'(cnt_valid), 0);

    // Held level counts once.
    win_len = 20; enable = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      pulse_in = (i >= 3 && i <= 7);
      if (i == 1) enable = 1'b0;
      tick();
    end
    check("held_valid", int'(cnt_valid), 1);
    check("held_out", int'(cnt_out), 1);
    idle(3);

    // Saturation: 300 events in a 700-cycle window, then 2 in the next.
    win_len = 700; enable = 1'b1;
    tick();
    for (int i = 1; i <= 700; i++) begin
      pulse_in = ((i % 2) == 1) && (i < 600);
      tick();
    end
    check("sat_valid", int'(cnt_valid), 1);
    check("sat_out", int'(cnt_out), 255);
    check("sat_ovf", int'(cnt_ovf), 1);
    for (int i = 1; i <= 700; i++) begin
      pulse_in = (i == 10 || i == 20);
      if (i == 1) enable = 1'b0;
      tick();
    end
    check("sat2_valid", int'(cnt_valid), 1);
    check("sat2_out", int'(cnt_out), 2);
    check("sat2_ovf", int'(cnt_ovf), 0);
    idle(3);

    // Backpressure: windows of 4 with counts 1, 2, 0; ready rises at the third end.
    cnt_ready = 1'b0; win_len = 4; enable = 1'b1;
    tick();
    for (int i = 1; i <= 12; i++) begin
      pulse_in = (i == 1 || i == 5 || i == 7);
      if (i == 12) begin
        cnt_ready = 1'b1;
        enable    = 1'b0;
      end
      tick();
      if (i >= 4) check("bp_valid_held", int'(cnt_valid), 1);
      if (i == 4) check("bp_first", int'(cnt_out), 1);
      if (i == 8) begin
        check("bp_hold_out", int'(cnt_out), 1);
        check("bp_drop", int'(drop), 1);
      end
      if (i == 9) check("bp_drop_one_cycle", int'(drop), 0);
      if (i == 12) check("bp_third", int'(cnt_out), 0);
    end
    idle(3);
    check("bp_drained", int'(cnt_valid), 0);

    // Zero window length: one-cycle windows with count 0 or 1.
    win_len = 0; enable = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      pulse_in = (i == 1 || i == 3 || i == 4 || i == 7);
      if (i == 8) enable = 1'b0;
      tick();
      check("w0_valid", int'(cnt_valid), 1);
      if (i == 1) check("w0_c1", int'(cnt_out), 0);
      if (i == 2) check("w0_c2", int'(cnt_out), 1);
      if (i == 3) check("w0_c3", int'(cnt_out), 0);
      if (i == 4) check("w0_c4", int'(cnt_out), 1);
      if (i == 5) check("w0_c5", int'(cnt_out), 0);
    end
    idle(3);

    // Reset mid-window after 2 counted events; the next window starts from 0.
    win_len = 10; enable = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      pulse_in = (i == 1 || i == 3);
      tick();
    end
    pulse_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(cnt_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      pulse_in = (i == 2);
      if (i == 1) enable = 1'b0;
      tick();
      if (i == 9) check("midrst_no_early", int'(cnt_valid), 0);
    end
    check("midrst_valid_after", int'(cnt_valid), 1);
    check("midrst_out", int'(cnt_out), 1);
    check("midrst_ovf", int'(cnt_ovf), 0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
